// File: rtl/pc_ctrl_pkg.sv
// Shared types and defaults for the fetch-stage PC hazard sequencer.
package pc_ctrl_pkg;

    localparam int unsigned ADDR_W       = 32;
    localparam int unsigned CNT_W_DEF    = 16;
    localparam int unsigned HOLD_MAX_DEF = 64;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        HOLD     = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SEL_SEQ = 2'd0,
        SEL_BR  = 2'd1,
        SEL_J   = 2'd2,
        SEL_JR  = 2'd3
    } pc_sel_e;

    // Instruction fetch addresses are always word aligned.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_hazard_sequencer_if.sv
// Request/control bundle between the ID-stage hazard logic and the fetch controller.
interface pc_hazard_sequencer_if #(
    parameter int unsigned CNT_W = pc_ctrl_pkg::CNT_W_DEF
);
    import pc_ctrl_pkg::*;

    logic [ADDR_W-1:0] PCPlus4;
    logic              BranchTaken;
    logic [ADDR_W-1:0] BranchTarget;
    logic              Jump;
    logic [ADDR_W-1:0] JumpTarget;
    logic              JumpReg;
    logic [ADDR_W-1:0] RegTarget;
    logic              LoadUse;
    logic              ExtStall;

    logic [ADDR_W-1:0] NextPC;
    logic              PCoff;
    logic              IFIDWrite;
    logic              IFIDFlush;
    logic              IDEXFlush;
    logic              StallTimeout;
    logic [CNT_W-1:0]  StallCount;
    logic [CNT_W-1:0]  FlushCount;

    modport slave (
        input  PCPlus4, BranchTaken, BranchTarget, Jump, JumpTarget,
               JumpReg, RegTarget, LoadUse, ExtStall,
        output NextPC, PCoff, IFIDWrite, IFIDFlush, IDEXFlush,
               StallTimeout, StallCount, FlushCount
    );

    modport master (
        output PCPlus4, BranchTaken, BranchTarget, Jump, JumpTarget,
               JumpReg, RegTarget, LoadUse, ExtStall,
        input  NextPC, PCoff, IFIDWrite, IFIDFlush, IDEXFlush,
               StallTimeout, StallCount, FlushCount
    );

endinterface

// File: rtl/pc_hazard_sequencer_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Inc,
    output logic [W-1:0] Count
);

    logic [W-1:0] r_count;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_count <= '0;
        end else if (Inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end
    end

    assign Count = r_count;

endmodule

// File: rtl/pc_hazard_sequencer.sv
// Fetch-stage controller: next-PC select, PC hold, IF/ID enable and flushes,
// load-use / external stall sequencing, stall timeout and perf counters.
module pc_hazard_sequencer
    import pc_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned HOLD_MAX = HOLD_MAX_DEF
) (
    input  logic                  Clk,
    input  logic                  Reset,
    pc_hazard_sequencer_if.slave  bus
);

    localparam int unsigned HOLD_W = $clog2(HOLD_MAX + 1);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [HOLD_W-1:0]   r_hold;
    logic [HOLD_W-1:0]   w_hold_nxt;
    logic                r_timeout;

    pc_sel_e             w_sel;
    logic [ADDR_W-1:0]   w_next_pc;
    logic                w_pcoff;
    logic                w_ifid_write;
    logic                w_ifid_flush;
    logic                w_idex_flush;
    logic                w_stall_inc;
    logic                w_flush_inc;
    logic [CNT_W-1:0]    w_stall_count;
    logic [CNT_W-1:0]    w_flush_count;

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request arbitration; while Reset is high the front end shows plain sequential fetch.
    always_comb begin
        w_state_nxt  = RUN;
        w_sel        = SEL_SEQ;
        w_pcoff      = 1'b0;
        w_ifid_write = 1'b1;
        w_ifid_flush = 1'b0;
        w_idex_flush = 1'b0;
        w_stall_inc  = 1'b0;
        w_flush_inc  = 1'b0;

        if (!Reset) begin
            if (bus.ExtStall) begin
                w_state_nxt  = HOLD;
                w_pcoff      = 1'b1;
                w_ifid_write = 1'b0;
                w_stall_inc  = 1'b1;
            end else if (bus.LoadUse && (r_state != LU_STALL)) begin
                // ID operands are not ready, so any redirect now would use stale values.
                w_state_nxt  = LU_STALL;
                w_pcoff      = 1'b1;
                w_ifid_write = 1'b0;
                w_idex_flush = 1'b1;
                w_stall_inc  = 1'b1;
            end else begin
                if (bus.JumpReg) begin
                    w_sel = SEL_JR;
                end else if (bus.Jump) begin
                    w_sel = SEL_J;
                end else if (bus.BranchTaken) begin
                    w_sel = SEL_BR;
                end
                if (w_sel != SEL_SEQ) begin
                    w_ifid_flush = 1'b1;
                    w_flush_inc  = 1'b1;
                end
            end
        end

        unique case (w_sel)
            SEL_JR:  w_next_pc = word_align(bus.RegTarget);
            SEL_J:   w_next_pc = word_align(bus.JumpTarget);
            SEL_BR:  w_next_pc = word_align(bus.BranchTarget);
            default: w_next_pc = word_align(bus.PCPlus4);
        endcase
    end

    // Consecutive external-stall cycle count, saturating at HOLD_MAX.
    always_comb begin
        w_hold_nxt = '0;
        if (bus.ExtStall) begin
            w_hold_nxt = (r_hold == HOLD_W'(HOLD_MAX)) ? r_hold : (r_hold + HOLD_W'(1));
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_hold    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_hold <= w_hold_nxt;
            if (bus.ExtStall && (w_hold_nxt == HOLD_W'(HOLD_MAX))) begin
                r_timeout <= 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .Inc   (w_stall_inc),
        .Count (w_stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .Inc   (w_flush_inc),
        .Count (w_flush_count)
    );

    assign bus.NextPC       = w_next_pc;
    assign bus.PCoff        = w_pcoff;
    assign bus.IFIDWrite    = w_ifid_write;
    assign bus.IFIDFlush    = w_ifid_flush;
    assign bus.IDEXFlush    = w_idex_flush;
    assign bus.StallTimeout = r_timeout;
    assign bus.StallCount   = w_stall_count;
    assign bus.FlushCount   = w_flush_count;

endmodule

// File: doc/pc_hazard_sequencer.md
# pc_hazard_sequencer

Controller for the fetch stage of the pipelined datapath. It selects the next value for the program counter (sequential, branch, jump, jump-register) and drives the program counter's stall input (PCoff). It also drives the IF/ID write-enable and the flush controls, based on hazard and control-flow requests. It enforces one-cycle load-use stalls, holds the front end during external stalls with a timeout flag, and keeps saturating stall and flush counters for performance debug.

## Interface
Parameters:
- CNT_W, 16, width of each performance counter
- HOLD_MAX, 64, number of consecutive ExtStall cycles before StallTimeout sets

Ports:
- Clk  in  1  clock; all state updates on the rising edge
- Reset  in  1  synchronous, active-high
- PCPlus4  in  32  sequential next address from the fetch adder
- BranchTaken  in  1  branch resolved taken in ID
- BranchTarget  in  32  branch target
- Jump  in  1  J/JAL in ID
- JumpTarget  in  32  jump target
- JumpReg  in  1  JR in ID
- RegTarget  in  32  register-sourced target
- LoadUse  in  1  load-use hazard detected in ID
- ExtStall  in  1  external (memory) stall request, level-sensitive
- NextPC  out  32  drives the PC's Address input
- PCoff  out  1  drives the PC's hold input
- IFIDWrite  out  1  IF/ID pipeline register enable
- IFIDFlush  out  1  squash the instruction in IF/ID
- IDEXFlush  out  1  insert a bubble into ID/EX
- StallTimeout  out  1  sticky error flag
- StallCount  out  CNT_W  saturating count of stall cycles
- FlushCount  out  CNT_W  saturating count of redirects

## Operation
- States: RUN, LU_STALL, HOLD. On reset: state=RUN, StallTimeout=0, StallCount=0, FlushCount=0, hold counter=0.
- Control outputs are combinational from state and inputs. Request priority, highest first: ExtStall > LoadUse > JumpReg > Jump > BranchTaken > sequential.
- ExtStall=1, any state:
  - PCoff=1, IFIDWrite=0, IFIDFlush=0, IDEXFlush=0, NextPC=PCPlus4.
  - Next state HOLD; hold counter increments, saturating at HOLD_MAX.
  - StallCount increments.
- HOLD with ExtStall=0: behaves as RUN for this cycle's requests; next state RUN; hold counter clears.
- LoadUse=1 in RUN (no ExtStall):
  - PCoff=1, IFIDWrite=0, IDEXFlush=1. Redirect inputs are ignored because ID operands are not ready.
  - Next state LU_STALL; StallCount increments.
- LU_STALL: LoadUse is ignored, giving at most one consecutive load-use stall cycle. Redirects and sequential fetch are evaluated as in RUN. Next state RUN unless ExtStall=1.
- Redirect (JumpReg, Jump or BranchTaken as the winner):
  - NextPC = the selected target with bits [1:0] forced to 00.
  - PCoff=0, IFIDWrite=1, IFIDFlush=1 for this cycle only, squashing the wrong-path fetch.
  - FlushCount increments.
- Sequential: NextPC = PCPlus4 with bits [1:0] forced to 00; PCoff=0, IFIDWrite=1, all flushes 0.
- Counters:
  - Saturate at 2^CNT_W-1; no wrap.
  - Update on the clock edge that ends the qualifying cycle.
- StallTimeout: sets on the edge where the hold counter reaches HOLD_MAX with ExtStall still 1. It is cleared only by Reset.
- Reset=1: overrides all other activity on that edge. While Reset is high, outputs show RUN/sequential values (PCoff=0, IFIDWrite=1, flushes 0).

## Timing
- Zero-cycle combinational path from request inputs to NextPC, PCoff and the flush/enable outputs. These must settle before the PC and pipeline-register edge.
- One-cycle latency for state, counters and StallTimeout.
- LoadUse held high for N cycles produces the pattern stall, run, stall, run, and so on. Each stall lasts exactly one cycle.
- ExtStall and LoadUse asserted together: ExtStall wins. The load-use stall is taken on the first cycle after ExtStall drops, if LoadUse is still high.
- Redirect asserted during ExtStall: suppressed. Because ID is held, the redirect is re-presented and taken on the first cycle after release.
- Reset asserted mid-HOLD or mid-LU_STALL: state and counters return to reset values on that edge.

## Structure
- Shared package pc_ctrl_pkg holds:
  - the state enum (RUN, LU_STALL, HOLD)
  - the next-PC select encoding (SEL_SEQ, SEL_BR, SEL_J, SEL_JR)
  - the default CNT_W and HOLD_MAX constants
- One sub-module, sat_counter (parameter W; ports Clk, Reset, Inc, Count), instantiated twice for StallCount and FlushCount.
- The hold counter is local to this block.

## Test plan
- Reset, then sequential fetch with PCPlus4=0x00000004: NextPC=0x00000004, PCoff=0, IFIDWrite=1, all counters 0.
- LoadUse held high for 4 cycles: PCoff pattern 1,0,1,0; IDEXFlush matches that pattern; StallCount=2.
- BranchTaken=1 and Jump=1 together, JumpTarget=0x00000040, BranchTarget=0x00000080: NextPC=0x00000040, IFIDFlush=1 for one cycle, FlushCount=1.
- ExtStall=1 for 3 cycles with JumpReg=1 and RegTarget=0x00000103 held: PCoff=1 for 3 cycles, no flush. On the 4th cycle NextPC=0x00000100 and IFIDFlush=1; StallCount=3, FlushCount=1.
- With HOLD_MAX=4, ExtStall held for 6 cycles: StallTimeout rises after the 4th edge and stays 1 after ExtStall drops, until Reset.
- CNT_W=3, 9 load-use stalls separated by run cycles: StallCount saturates at 7; Reset mid-stall clears it to 0 and returns to RUN on the same edge.
